serial_bit_gen: RTL and testbench
=================================

# serial_bit_gen

Parallel-in, serial-out stimulus generator that sits directly upstream of the lab sequence detectors, including the Moore 0-1-0-0-1-0 detector. On a start request it captures a WIDTH-bit word and emits it MSB-first on a single serial line, holding each bit for DIV clock cycles, then returns the line to idle. It exists so a board test can drive any bit pattern from switches into a detector's serial input `e`, one button press at a time, at a selectable rate.

## Interface
- `WIDTH`, default 8: number of bits per transmission, minimum 2.
- `DIV`, default 1: clock cycles each bit is held, minimum 1. DIV=1 gives one bit per `clk`, which is the rate a detector sampling `e` every cycle expects.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: transmission request, level input, already synchronous to `clk`. Only its rising edge is used.
- `din` input WIDTH: word to send, captured on the accepting edge.
- `e_out` output 1: serial data, MSB first. Idle level is 1.
- `bit_tick` output 1: one-cycle strobe in the first cycle each new bit is valid on `e_out`.
- `busy` output 1: high while bits are being sent.
- `done` output 1: one-cycle pulse after the last bit completes.

## Operation
- States:
  - IDLE: `e_out`=1, `busy`=0.
  - SHIFT: bits are being sent.
  - DONE: lasts exactly one cycle, then always goes to IDLE.
- Edge detect: `start_d` is `start` registered. An accept occurs when `start`=1, `start_d`=0 and the state is IDLE.
- Rising edges of `start` that arrive in SHIFT or DONE are dropped; they are neither queued nor replayed.
- On accept:
  - `shreg`<=`din`, `bitcnt`<=0, `presc`<=0, state<=SHIFT.
  - On the same edge, `e_out`<=`din[WIDTH-1]`, `bit_tick`<=1, `busy`<=1.
- In SHIFT, `presc` counts from 0 to DIV-1. When `presc`=DIV-1:
  - If `bitcnt`<WIDTH-1: shift `shreg` left, `e_out`<=next bit, `bitcnt`+1, `presc`<=0, `bit_tick`<=1.
  - If `bitcnt`=WIDTH-1: `e_out`<=1, `busy`<=0, `done`<=1, state<=DONE.
- `bit_tick` is 0 in every cycle except those listed above.
- Counter widths:
  - `bitcnt` is $clog2(WIDTH) bits.
  - `presc` is max(1,$clog2(DIV)) bits.
  - Neither counter ever wraps past its terminal value.
- `din` changes after the accepting edge have no effect on the word in flight.
- Reset (rst=1 at a rising edge):
  - state=IDLE, `e_out`=1, `busy`=0, `done`=0, `bit_tick`=0, `shreg`=0, counters=0.
  - `start_d`=1, so a `start` held high across reset release does not trigger a transmission.
- Reset mid-transmission aborts immediately: no `done` pulse, and the line returns to 1 on the next cycle.

## Timing
- Accept at edge n: bit k (k=0..WIDTH-1) is on `e_out` during cycles n+k·DIV through n+(k+1)·DIV−1.
- `bit_tick` is high in cycle n+k·DIV for each k.
- `busy` is high for exactly WIDTH·DIV cycles.
- `done` is high in cycle n+WIDTH·DIV, the same cycle `e_out` returns to 1.
- The earliest next accept is the edge ending cycle n+WIDTH·DIV+1, i.e. the first IDLE cycle with a fresh rising edge on `start`.
- Latency from `start` rising to first bit is one edge. The generator adds no other pipeline delay.

## Test plan
- Reset: hold rst for 3 cycles with `start`=1, release, and keep `start`=1 for 10 cycles. Required: `e_out`=1, `busy`=0, `done`=0, `bit_tick`=0 throughout, with no transmission.
- WIDTH=8, DIV=1, `din`=8'h4B, one-cycle `start` pulse. Required: `e_out`=0,1,0,0,1,0,1,1 on 8 consecutive cycles, `bit_tick` high on all 8, `busy` high for 8 cycles, `done` high on the 9th cycle with `e_out`=1.
- Same word with DIV=4:
  - Each bit is held 4 cycles.
  - `bit_tick` fires every 4th cycle, 8 times in total.
  - `done` fires exactly 32 cycles after the first bit.
  - `din` is changed to 8'hFF in the cycle after accept, and the transmitted bits are unaffected.
- Start handling, WIDTH=8, DIV=1:
  - `start` held high for 20 cycles gives exactly one transmission.
  - A second `start` rising edge during bit 4 is ignored.
  - A rising edge in the first IDLE cycle after DONE starts a new word.
- Reset mid-transmission: assert rst during bit 3. Required: the next cycle has `e_out`=1 and `busy`=0, and `done` never pulses for that word.
- Chained with the 0-1-0-0-1-0 detector using `e_out` to `e` and DIV=1:
  - `din`=8'h4B drives the detector output to 1 within one cycle of the sixth bit.
  - `din`=8'hFF leaves the detector output at 0.

Source files
------------

// File: rtl/serial_bit_gen_if.sv
// serial_bit_gen_if: request/data/status bundle for serial_bit_gen.
//   start    - transmission request level (rising edge accepted in IDLE)
//   din      - WIDTH-bit word, captured on the accepting edge
//   e_out    - serial line, MSB first, idles at 1
//   bit_tick - one-cycle strobe when a new bit appears on e_out
//   busy     - high while bits are being sent
//   done     - one-cycle pulse after the last bit completes
// master: the requester (drives start/din). slave: the generator.
interface serial_bit_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             e_out;
    logic             bit_tick;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output din,
        input  e_out,
        input  bit_tick,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  din,
        output e_out,
        output bit_tick,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_bit_gen.sv
// serial_bit_gen: parallel-in, serial-out bit pattern generator.
// On a rising edge of start while idle, captures din and sends it MSB first on e_out,
// holding each bit for DIV clocks, then pulses done and returns the line to 1.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - serial_bit_gen_if.slave (start, din in; e_out, bit_tick, busy, done out)
module serial_bit_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input logic             clk,
    input logic             rst,
    serial_bit_gen_if.slave bus
);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] LastBit   = BW'(WIDTH - 1);
    localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic             start_d_q, start_d_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             e_out_q, e_out_d;
    logic             bit_tick_q, bit_tick_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            // Treat start as already high so a level held through reset is not an edge.
            start_d_q  <= 1'b1;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            presc_q    <= '0;
            e_out_q    <= 1'b1;
            bit_tick_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_d_q  <= start_d_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            presc_q    <= presc_d;
            e_out_q    <= e_out_d;
            bit_tick_q <= bit_tick_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d_d  = bus.start;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        presc_d    = presc_q;
        e_out_d    = e_out_q;
        bit_tick_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Edges arriving outside IDLE are simply lost, never queued.
                if (bus.start && !start_d_q) begin
                    shreg_d    = bus.din;
                    bitcnt_d   = '0;
                    presc_d    = '0;
                    e_out_d    = bus.din[WIDTH-1];
                    bit_tick_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (presc_q == PrescLast) begin
                    if (bitcnt_q != LastBit) begin
                        shreg_d    = shreg_q << 1;
                        // Bit that becomes the MSB after this shift.
                        e_out_d    = shreg_q[WIDTH-2];
                        bitcnt_d   = bitcnt_q + 1'b1;
                        presc_d    = '0;
                        bit_tick_d = 1'b1;
                    end else begin
                        e_out_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.e_out    = e_out_q;
    assign bus.bit_tick = bit_tick_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_bit_gen.sv
// tb_serial_bit_gen: self-checking bench for serial_bit_gen with DIV=1 and DIV=4 instances.
// Expected bits are queued when a word is launched and popped on each bit_tick.
module tb_serial_bit_gen;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_bit_gen_if #(.WIDTH(W)) if1 ();
    serial_bit_gen_if #(.WIDTH(W)) if4 ();

    serial_bit_gen #(.WIDTH(W), .DIV(1)) u_div1 (.clk(clk), .rst(rst), .bus(if1));
    serial_bit_gen #(.WIDTH(W), .DIV(4)) u_div4 (.clk(clk), .rst(rst), .bus(if4));

    int   checks = 0;
    int   errors = 0;
    bit   sel4   = 1'b0;
    logic q[$];

    logic s_e, s_tick, s_busy, s_done;
    always_comb begin
        if (sel4) begin
            s_e = if4.e_out; s_tick = if4.bit_tick; s_busy = if4.busy; s_done = if4.done;
        end else begin
            s_e = if1.e_out; s_tick = if1.bit_tick; s_busy = if1.busy; s_done = if1.done;
        end
    end

    // Moore 0-1-0-0-1-0 detector on the DIV=1 line (overlapping, output from state).
    logic [5:0] hist;
    logic       det;
    always_ff @(posedge clk) begin
        if (rst) hist <= 6'h3F;
        else     hist <= {hist[4:0], if1.e_out};
    end
    assign det = (hist == 6'b010010);

    task automatic set_start(input logic v);
        if (sel4) if4.start = v;
        else      if1.start = v;
    endtask

    task automatic set_din(input logic [W-1:0] d);
        if (sel4) if4.din = d;
        else      if1.din = d;
    endtask

    // Launch word w and check every cycle until done plus `tail` idle cycles.
    // start is held start_len cycles; glitch>0 adds a second rising edge in cycle `glitch`.
    task automatic xmit(input logic [W-1:0] w, input int div, input int start_len,
                        input int glitch, input bit chg, input int tail, input string name);
        int   ticks = 0;
        logic cur   = 1'b1;
        logic exp_tick;
        set_din(w);
        set_start(1'b1);
        for (int k = W - 1; k >= 0; k--) q.push_back(w[k]);
        for (int c = 0; c < int'(W) * div + 1 + tail; c++) begin
            @(negedge clk);
            if (c < int'(W) * div) begin
                exp_tick = ((c % div) == 0);
                checks++;
                if (s_tick !== exp_tick)
                    $display("FAIL %s tick c=%0d got %b exp %b", name, c, s_tick, exp_tick);
                if (s_tick !== exp_tick) errors++;
                if (exp_tick) begin
                    checks++;
                    if (q.size() == 0) begin
                        $display("FAIL %s queue empty c=%0d", name, c);
                        errors++;
                    end else begin
                        cur = q.pop_front();
                    end
                end
                checks++;
                if (s_e !== cur || s_busy !== 1'b1 || s_done !== 1'b0) begin
                    $display("FAIL %s data c=%0d got e=%b busy=%b done=%b exp e=%b busy=1 done=0",
                             name, c, s_e, s_busy, s_done, cur);
                    errors++;
                end
            end else if (c == int'(W) * div) begin
                checks++;
                if ({s_e, s_tick, s_busy, s_done} !== 4'b1001) begin
                    $display("FAIL %s done c=%0d got e/tick/busy/done=%b exp 1001",
                             name, c, {s_e, s_tick, s_busy, s_done});
                    errors++;
                end
            end else begin
                checks++;
                if ({s_e, s_tick, s_busy, s_done} !== 4'b1000) begin
                    $display("FAIL %s idle c=%0d got e/tick/busy/done=%b exp 1000",
                             name, c, {s_e, s_tick, s_busy, s_done});
                    errors++;
                end
            end
            if (s_tick === 1'b1) ticks++;
            if (c + 1 >= start_len) set_start(1'b0);
            if (glitch > 0 && c == glitch - 1) set_start(1'b1);
            if (glitch > 0 && c == glitch) set_start(1'b0);
            if (chg && c == 0) set_din(8'hFF);
        end
        checks++;
        if (ticks != int'(W)) begin
            $display("FAIL %s tick_count got %0d exp %0d", name, ticks, W);
            errors++;
        end
        checks++;
        if (q.size() != 0) begin
            $display("FAIL %s leftover got %0d exp 0", name, q.size());
            errors++;
        end
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if1.start = 1'b1; if1.din = 8'hA5;
        if4.start = 1'b1; if4.din = 8'hA5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({if1.e_out, if1.bit_tick, if1.busy, if1.done} !== 4'b1000) begin
                $display("FAIL reset_div1 i=%0d got %b exp 1000", i,
                         {if1.e_out, if1.bit_tick, if1.busy, if1.done});
                errors++;
            end
            checks++;
            if ({if4.e_out, if4.bit_tick, if4.busy, if4.done} !== 4'b1000) begin
                $display("FAIL reset_div4 i=%0d got %b exp 1000", i,
                         {if4.e_out, if4.bit_tick, if4.busy, if4.done});
                errors++;
            end
        end
        if1.start = 1'b0;
        if4.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        sel4 = 1'b0;
        xmit(8'h4B, 1, 1, 0, 1'b0, 2, "basic_div1");
    endtask

    task automatic test_div4();
        sel4 = 1'b1;
        xmit(8'h4B, 4, 1, 0, 1'b1, 2, "div4");
        sel4 = 1'b0;
    endtask

    task automatic test_start_held();
        sel4 = 1'b0;
        xmit(8'hA6, 1, 20, 0, 1'b0, 12, "start_held");
    endtask

    task automatic test_ignore();
        sel4 = 1'b0;
        xmit(8'h35, 1, 1, 4, 1'b0, 3, "ignore_edge");
    endtask

    task automatic test_back_to_back();
        sel4 = 1'b0;
        xmit(8'hC3, 1, 1, 0, 1'b0, 1, "b2b_first");
        xmit(8'h5A, 1, 1, 0, 1'b0, 2, "b2b_second");
    endtask

    task automatic test_reset_mid();
        sel4 = 1'b0;
        set_din(8'h4B);
        set_start(1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_start(1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_e, s_busy, s_done} !== 3'b100) begin
            $display("FAIL reset_mid got e/busy/done=%b exp 100", {s_e, s_busy, s_done});
            errors++;
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (s_done !== 1'b0 || s_busy !== 1'b0) begin
                $display("FAIL reset_mid_after c=%0d got busy=%b done=%b exp 0 0",
                         c, s_busy, s_done);
                errors++;
            end
        end
    endtask

    task automatic test_detector();
        sel4 = 1'b0;
        set_din(8'h4B);
        set_start(1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            set_start(1'b0);
            checks++;
            if (det !== (c == 6)) begin
                $display("FAIL detect_4B c=%0d got %b exp %b", c, det, (c == 6));
                errors++;
            end
        end
        set_din(8'hFF);
        set_start(1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            set_start(1'b0);
            checks++;
            if (det !== 1'b0) begin
                $display("FAIL detect_FF c=%0d got %b exp 0", c, det);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div4();
        test_start_held();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_detector();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
